// File: rtl/mem_preload_ctrl.sv
// Memory preload/verify engine: streams an image into a single-port RAM from a
// base address, optionally re-streams it and compares against readback.
module mem_preload_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic                  verify_en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [ADDR_WIDTH-1:0] first_bad_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_VERIFY, S_DRAIN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  ver_q, ver_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  pipe_v_q, pipe_v_d;
  logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  mcnt_q, mcnt_d;
  logic [ADDR_WIDTH-1:0] fba_q, fba_d;
  logic                  hs;

  // Strobes are gated by reset so nothing reaches memory during the reset cycle.
  assign s_ready   = reset_n && (state_q == S_WRITE || state_q == S_VERIFY);
  assign hs        = s_ready && s_valid;
  assign mem_we    = hs && (state_q == S_WRITE);
  assign mem_re    = hs && (state_q == S_VERIFY);
  assign mem_addr  = (mem_we || mem_re) ? ptr_q : '0;
  assign mem_wdata = mem_we ? s_data : '0;
  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_DONE);
  assign err            = err_q;
  assign mismatch_cnt   = mcnt_q;
  assign first_bad_addr = fba_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      ver_q       <= 1'b0;
      ptr_q       <= '0;
      rem_q       <= '0;
      pipe_v_q    <= 1'b0;
      pipe_data_q <= '0;
      pipe_addr_q <= '0;
      err_q       <= 1'b0;
      mcnt_q      <= '0;
      fba_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      ver_q       <= ver_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      pipe_v_q    <= pipe_v_d;
      pipe_data_q <= pipe_data_d;
      pipe_addr_q <= pipe_addr_d;
      err_q       <= err_d;
      mcnt_q      <= mcnt_d;
      fba_q       <= fba_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    ver_d       = ver_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    pipe_v_d    = 1'b0;
    pipe_data_d = pipe_data_q;
    pipe_addr_d = pipe_addr_q;
    err_d       = err_q;
    mcnt_d      = mcnt_q;
    fba_d       = fba_q;

    // Compare the word read on the previous cycle against its piped expectation.
    if (pipe_v_q && (state_q == S_VERIFY || state_q == S_DRAIN) &&
        (mem_rdata != pipe_data_q)) begin
      if (mcnt_q == '0) fba_d = pipe_addr_q;
      if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          ver_d   = verify_en;
          ptr_d   = base_addr;
          rem_d   = length;
          err_d   = 1'b0;
          mcnt_d  = '0;
          fba_d   = '0;
          state_d = (length == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (hs) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            if (ver_q) begin
              ptr_d   = base_q;
              rem_d   = len_q;
              state_d = S_VERIFY;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_VERIFY: begin
        if (hs) begin
          pipe_v_d    = 1'b1;
          pipe_data_d = s_data;
          pipe_addr_d = ptr_q;
          ptr_d       = ptr_q + ADDR_WIDTH'(1);
          rem_d       = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        err_d   = (mcnt_q != '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Directed self-checking bench for mem_preload_ctrl with a behavioural RAM
// that logs every write and read strobe.
module tb_mem_preload_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        verify_en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we, mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_hold, busy, done, err;
  logic [16:0] mismatch_cnt;
  logic [15:0] first_bad_addr;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          wr_cyc_q  [$];
  logic [15:0] rd_addr_q [$];
  int          cyc = 0;
  int          both_cnt = 0;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  logic [7:0]  corrupt_data = '0;

  mem_preload_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .verify_en(verify_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .mismatch_cnt(mismatch_cnt),
    .first_bad_addr(first_bad_addr)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, plus a backdoor used to corrupt a word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end else if (corrupt_en) begin
      mem[corrupt_addr] <= corrupt_data;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      rd_addr_q.push_back(mem_addr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] b, input logic [16:0] l, input logic v);
    start = 1'b1; base_addr = b; length = l; verify_en = v;
    tick;
    start = 1'b0; base_addr = 16'hDEAD; length = 17'h1FFFF; verify_en = ~v;
  endtask

  // Presents one word and returns once it has been accepted; s_valid is left high.
  task automatic send_word(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) begin
      checks++; failures++;
      $display("FAIL send_word_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end
    tick;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%0b, required 1", name, done);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; verify_en = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) tick;
    checks++;
    if ({s_ready, mem_we, mem_re, mem_addr, mem_wdata, cpu_hold, busy, done, err,
         mismatch_cnt, first_bad_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b mcnt=%0d fba=%h, required all 0",
               busy, done, err, mismatch_cnt, first_bad_addr);
    end
    reset_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b s_ready=%0b, required 0 0", busy, s_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] d [0:3];
    int w0;
    d = '{8'hA9, 8'h01, 8'h8D, 8'h00};
    w0 = wr_addr_q.size();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL basic_busy_pre: busy=%0b, required 0", busy);
    end
    start_job(16'h0000, 17'd4, 1'b0);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL basic_hold_rise: busy=%0b hold=%0b, required 1 1", busy, cpu_hold);
    end
    for (int i = 0; i < 4; i++) send_word(d[i]);
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL basic_done_pulse: done=%0b hold=%0b, required 1 1", done, cpu_hold);
    end
    tick;
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_done: done=%0b hold=%0b err=%0b, required 0 0 0", done, cpu_hold, err);
    end
    checks++;
    if (wr_addr_q.size() != w0 + 4) begin
      failures++; $display("FAIL basic_wr_count: got=%0d, required 4", wr_addr_q.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[w0+i] !== 16'(i) || wr_data_q[w0+i] !== d[i] ||
            wr_cyc_q[w0+i] != wr_cyc_q[w0] + i) begin
          failures++;
          $display("FAIL basic_write%0d: addr=%h data=%h, required addr=%h data=%h consecutive",
                   i, wr_addr_q[w0+i], wr_data_q[w0+i], 16'(i), d[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_verify;
    logic [7:0]  d [0:3];
    logic [15:0] a [0:3];
    int w0, r0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size();
    start_job(16'hFFFE, 17'd4, 1'b1);
    for (int i = 0; i < 4; i++) send_word(d[i]);
    for (int i = 0; i < 4; i++) send_word(d[i]);
    s_valid = 1'b0;
    wait_done("wrap");
    checks++;
    if (mismatch_cnt !== 17'd0 || first_bad_addr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_mismatch: mcnt=%0d fba=%h, required 0 0000", mismatch_cnt, first_bad_addr);
    end
    tick;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL wrap_err: err=%0b, required 0", err);
    end
    checks++;
    if (wr_addr_q.size() != w0 + 4 || rd_addr_q.size() != r0 + 4) begin
      failures++;
      $display("FAIL wrap_counts: writes=%0d reads=%0d, required 4 4",
               wr_addr_q.size() - w0, rd_addr_q.size() - r0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[w0+i] !== a[i] || rd_addr_q[r0+i] !== a[i]) begin
          failures++;
          $display("FAIL wrap_addr%0d: wr=%h rd=%h, required %h", i, wr_addr_q[w0+i],
                   rd_addr_q[r0+i], a[i]);
        end
      end
    end
  endtask

  task automatic test_mismatch;
    logic [7:0] d [0:2];
    d = '{8'h10, 8'h20, 8'h30};
    start_job(16'h0200, 17'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_word(d[i]);
    s_valid = 1'b0;
    corrupt_en = 1'b1; corrupt_addr = 16'h0201; corrupt_data = 8'h55;
    tick;
    corrupt_en = 1'b0;
    for (int i = 0; i < 3; i++) send_word(d[i]);
    s_valid = 1'b0;
    wait_done("mismatch");
    checks++;
    if (mismatch_cnt !== 17'd1 || first_bad_addr !== 16'h0201) begin
      failures++;
      $display("FAIL mismatch_result: mcnt=%0d fba=%h, required 1 0201", mismatch_cnt, first_bad_addr);
    end
    repeat (4) tick;
    checks++;
    if (err !== 1'b1 || mismatch_cnt !== 17'd1) begin
      failures++; $display("FAIL mismatch_err_held: err=%0b mcnt=%0d, required 1 1", err, mismatch_cnt);
    end
  endtask

  task automatic test_len0;
    int w0, r0;
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size();
    start_job(16'h1234, 17'd0, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || err !== 1'b0 || mismatch_cnt !== 17'd0 ||
        first_bad_addr !== 16'h0000) begin
      failures++;
      $display("FAIL len0_done: busy=%0b done=%0b err=%0b mcnt=%0d fba=%h, required 1 1 0 0 0000",
               busy, done, err, mismatch_cnt, first_bad_addr);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL len0_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
    repeat (2) tick;
    checks++;
    if (wr_addr_q.size() != w0 || rd_addr_q.size() != r0) begin
      failures++;
      $display("FAIL len0_strobes: writes=%0d reads=%0d, required 0 0",
               wr_addr_q.size() - w0, rd_addr_q.size() - r0);
    end
  endtask

  task automatic test_bubbles;
    int w0;
    w0 = wr_addr_q.size();
    start_job(16'h0100, 17'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_word(8'(8'h40 + i));
      if (i < 7) begin
        s_valid = 1'b0;
        if (i == 2) begin
          start = 1'b1; base_addr = 16'h5000; length = 17'd2; verify_en = 1'b1;
        end
        tick;
        start = 1'b0;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL bubbles_done: done=%0b, required 1", done);
    end
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != w0 + 8) begin
      failures++;
      $display("FAIL bubbles_count: busy=%0b writes=%0d, required 0 8", busy, wr_addr_q.size() - w0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr_q[w0+i] !== 16'(16'h0100 + i) || wr_data_q[w0+i] !== 8'(8'h40 + i)) begin
          failures++;
          $display("FAIL bubbles_write%0d: addr=%h data=%h, required %h %h", i, wr_addr_q[w0+i],
                   wr_data_q[w0+i], 16'(16'h0100 + i), 8'(8'h40 + i));
        end
      end
    end
  endtask

  task automatic test_reset_midjob;
    int w0;
    w0 = wr_addr_q.size();
    start_job(16'h0300, 17'd6, 1'b0);
    send_word(8'hC1);
    send_word(8'hC2);
    s_data  = 8'h77;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      failures++; $display("FAIL rstmid_strobe_in_reset: we=%0b re=%0b, required 0 0", mem_we, mem_re);
    end
    tick;
    checks++;
    if ({s_ready, mem_we, mem_re, mem_addr, mem_wdata, cpu_hold, busy, done, err,
         mismatch_cnt, first_bad_addr} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: s_ready=%0b we=%0b busy=%0b addr=%h, required all 0",
               s_ready, mem_we, busy, mem_addr);
    end
    reset_n = 1'b1;
    repeat (3) tick;
    s_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != w0 + 2) begin
      failures++; $display("FAIL rstmid_writes: got=%0d, required 2", wr_addr_q.size() - w0);
    end
    start_job(16'h0400, 17'd1, 1'b0);
    send_word(8'h99);
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_addr_q.size() != w0 + 3 ||
        wr_addr_q[wr_addr_q.size()-1] !== 16'h0400 || wr_data_q[wr_data_q.size()-1] !== 8'h99) begin
      failures++;
      $display("FAIL rstmid_restart: done=%0b writes=%0d last_addr=%h, required 1 3 0400",
               done, wr_addr_q.size() - w0, wr_addr_q[wr_addr_q.size()-1]);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap_verify;
    test_mismatch;
    test_len0;
    test_bubbles;
    test_reset_midjob;
    checks++;
    if (both_cnt != 0) begin
      failures++; $display("FAIL we_re_exclusive: overlaps=%0d, required 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
